// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage: widens an IN_W-bit immediate according to MODE and
// queues the result in a 2-entry valid/ready buffer that decouples decode from execute.
module imm_ext_pipe #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  IN,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUT,
  output logic [1:0]       OUT_MODE
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } mode_e;

  function automatic logic signed [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                     input logic [1:0]      md);
    logic signed [OUT_W-1:0] sext;
    sext = {{PAD_W{imm[IN_W-1]}}, imm};
    case (mode_e'(md))
      MODE_ZERO:   extend = {{PAD_W{1'b0}}, imm};
      MODE_SIGN:   extend = sext;
      MODE_UPPER:  extend = {imm, {PAD_W{1'b0}}};
      default:     extend = sext <<< 2;
    endcase
  endfunction

  // Stage p0: combinational extension of the presented immediate
  logic signed [OUT_W-1:0] ext_p0;
  logic        [1:0]       mode_p0;

  assign ext_p0  = extend(IN, MODE);
  assign mode_p0 = MODE;

  // Stage p1: two-entry buffer, head drives the outputs
  logic signed [OUT_W-1:0] head_p1;
  logic        [1:0]       head_mode_p1;
  logic signed [OUT_W-1:0] tail_p1;
  logic        [1:0]       tail_mode_p1;
  logic        [1:0]       cnt_p1;
  logic                    push;
  logic                    pop;

  assign IN_READY  = (cnt_p1 != 2'd2);
  assign OUT_VALID = (cnt_p1 != 2'd0);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;
  assign OUT       = head_p1;
  assign OUT_MODE  = head_mode_p1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p1       <= 2'd0;
      head_p1      <= '0;
      head_mode_p1 <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_p1 == 2'd0) begin
            head_p1      <= ext_p0;
            head_mode_p1 <= mode_p0;
          end
          cnt_p1 <= cnt_p1 + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves the stale head in place rather than clearing it.
          if (cnt_p1 == 2'd2) begin
            head_p1      <= tail_p1;
            head_mode_p1 <= tail_mode_p1;
          end
          cnt_p1 <= cnt_p1 - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new word replaces the departing head.
          head_p1      <= ext_p0;
          head_mode_p1 <= mode_p0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !pop && cnt_p1 == 2'd1) begin
      tail_p1      <= ext_p0;
      tail_mode_p1 <= mode_p0;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: directed vectors plus random valid/ready traffic scored
// against an arithmetic reference model and a queue of expected results.
module tb_imm_ext_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [19:0] IN = '0;
  logic [1:0]  MODE = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT;
  logic [1:0]  OUT_MODE;

  logic        IN_VALID12 = 1'b0;
  logic        IN_READY12;
  logic [11:0] IN12 = '0;
  logic [1:0]  MODE12 = '0;
  logic        OUT_VALID12;
  logic        OUT_READY12 = 1'b0;
  logic [31:0] OUT12;
  logic [1:0]  OUT_MODE12;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
  } ent_t;
  ent_t q[$];

  always #5 CLK = ~CLK;

  imm_ext_pipe #(.IN_W(20), .OUT_W(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN(IN), .MODE(MODE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .OUT_MODE(OUT_MODE)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(32)) dut12 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID12), .IN_READY(IN_READY12), .IN(IN12), .MODE(MODE12),
    .OUT_VALID(OUT_VALID12), .OUT_READY(OUT_READY12), .OUT(OUT12), .OUT_MODE(OUT_MODE12)
  );

  // Reference: interpret the field as an integer, then place it arithmetically.
  function automatic logic [31:0] model(input logic [63:0] imm, input int inw, input logic [1:0] md);
    logic [63:0] u;
    longint      s;
    logic [63:0] r;
    u = imm & ((64'd1 << inw) - 64'd1);
    s = longint'(u);
    if (u[inw-1]) s = s - (longint'(1) << inw);
    case (md)
      2'd0:    r = u;
      2'd1:    r = s;
      2'd2:    r = u << (32 - inw);
      default: r = s * 4;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit v, input logic [19:0] imm, input logic [1:0] md,
                       input bit rdy, input bit rst_i);
    bit acc_in;
    bit acc_out;
    @(negedge CLK);
    RST = rst_i; IN_VALID = v; IN = imm; MODE = md; OUT_READY = rdy;
    #1;
    chk("out_valid", {63'd0, OUT_VALID}, {63'd0, q.size() != 0});
    chk("in_ready", {63'd0, IN_READY}, {63'd0, q.size() < 2});
    if (q.size() != 0) begin
      chk("out_head", {32'd0, OUT}, {32'd0, q[0].data});
      chk("out_mode", {62'd0, OUT_MODE}, {62'd0, q[0].mode});
    end
    acc_in  = v && (q.size() < 2);
    acc_out = (q.size() != 0) && rdy;
    @(posedge CLK);
    if (rst_i) q.delete();
    else begin
      if (acc_out) void'(q.pop_front());
      if (acc_in) q.push_back('{model({44'd0, imm}, 20, md), md});
    end
  endtask

  task automatic expect_head(input string tag, input logic [31:0] exp, input logic [1:0] md);
    #1;
    chk({tag, "_valid"}, {63'd0, OUT_VALID}, 64'd1);
    chk(tag, {32'd0, OUT}, {32'd0, exp});
    chk({tag, "_mode"}, {62'd0, OUT_MODE}, {62'd0, md});
  endtask

  initial begin
    logic [31:0] held;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("rst_in_ready", {63'd0, IN_READY}, 64'd1);
    chk("rst_out", {32'd0, OUT}, 64'd0);
    chk("rst_out_mode", {62'd0, OUT_MODE}, 64'd0);

    // Same field through all four modes, back to back.
    cycle(1, 20'hFFFFF, 2'd0, 1, 0); expect_head("zero_ffff", 32'h000FFFFF, 2'd0);
    cycle(1, 20'hFFFFF, 2'd1, 1, 0); expect_head("sign_ffff", 32'hFFFFFFFF, 2'd1);
    cycle(1, 20'hFFFFF, 2'd2, 1, 0); expect_head("upper_ffff", 32'hFFFFF000, 2'd2);
    cycle(1, 20'hFFFFF, 2'd3, 1, 0); expect_head("branch_ffff", 32'hFFFFFFFC, 2'd3);
    cycle(1, 20'h80001, 2'd3, 1, 0); expect_head("branch_80001", 32'hFFE00004, 2'd3);
    cycle(1, 20'h12345, 2'd2, 1, 0); expect_head("upper_12345", 32'h12345000, 2'd2);
    cycle(1, 20'h7FFFF, 2'd1, 1, 0); expect_head("sign_7ffff", 32'h0007FFFF, 2'd1);
    cycle(0, 20'h0, 2'd0, 1, 0);

    // Stall: A and B fill the buffer, C is held off.
    cycle(1, 20'h0000A, 2'd0, 0, 0);
    cycle(1, 20'h0000B, 2'd1, 0, 0);
    cycle(1, 20'h0000C, 2'd2, 0, 0);
    #1;
    chk("full_in_ready", {63'd0, IN_READY}, 64'd0);
    held = OUT;
    chk("stall_head_a", {32'd0, held}, 64'h0000_0000_0000_000A);
    repeat (4) cycle(1, 20'h0000C, 2'd2, 0, 0);
    #1;
    chk("stall_stable", {32'd0, OUT}, {32'd0, held});
    cycle(1, 20'h0000C, 2'd2, 1, 0);
    cycle(1, 20'h0000C, 2'd2, 1, 0);
    cycle(0, 20'h0, 2'd0, 1, 0);
    cycle(0, 20'h0, 2'd0, 1, 0);

    // Reset while full discards everything in flight.
    cycle(1, 20'h11111, 2'd0, 0, 0);
    cycle(1, 20'h22222, 2'd1, 0, 0);
    cycle(0, 20'h0, 2'd0, 0, 1);
    #1;
    chk("rst_full_out_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("rst_full_in_ready", {63'd0, IN_READY}, 64'd1);
    chk("rst_full_out", {32'd0, OUT}, 64'd0);
    repeat (3) cycle(0, 20'h0, 2'd0, 1, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), 20'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    while (q.size() != 0) cycle(0, 20'h0, 2'd0, 1, 0);

    // Narrow instance.
    @(negedge CLK);
    IN_VALID12 = 1; IN12 = 12'h800; MODE12 = 2'd1; OUT_READY12 = 1;
    @(negedge CLK);
    chk("w12_sign", {32'd0, OUT12}, 64'h0000_0000_FFFF_F800);
    chk("w12_sign_model", {32'd0, OUT12}, {32'd0, model(64'h800, 12, 2'd1)});
    MODE12 = 2'd3;
    @(negedge CLK);
    chk("w12_branch", {32'd0, OUT12}, 64'h0000_0000_FFFF_E000);
    chk("w12_branch_mode", {62'd0, OUT_MODE12}, 64'd3);
    IN_VALID12 = 0;
    @(negedge CLK);
    chk("w12_drained", {63'd0, OUT_VALID12}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
